data_memory_responder: RTL and testbench

Multi-cycle data memory that acts as the responder on the CPU data-memory request/response interface. It replaces the single-cycle combinational data memory once the core stalls on memory. It accepts one word read or write request at a time, waits a fixed number of cycles, then returns a response that is held until the core takes it.

---
 rtl/data_memory_responder.sv | 139 +++++++++++++
 tb/tb_data_memory_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - multi-cycle data memory responder (optional DMEM_ALIGN_CHECK_EN misaligned-access check)
module data_memory_responder #(
    parameter int DEPTH   = 16384,
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [CW-1:0]   r_cnt;
    logic            r_write;
    logic [AW-1:0]   r_idx;
    logic [31:0]     r_wdata;
    logic            r_misaligned;
    logic [31:0]     r_rdata;
    logic            r_err;
    logic [31:0]     r_mem [DEPTH];

    logic            w_accept;
    logic            w_done;
    logic            w_mem_we;
    logic            w_req_misaligned;
    logic            w_unused;

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_req_misaligned = (req_addr[1:0] != 2'b00);
`else
    assign w_req_misaligned = 1'b0;
`endif

    // Upper address bits wrap away; low bits only matter for the alignment check.
    assign w_unused = &{1'b0, req_addr[31:AW+2], req_addr[1:0]};

    // Next-state logic and handshake outputs, decoded from the current state.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        resp_valid   = 1'b0;
        w_accept     = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == '0) begin
                    w_done       = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Request capture, latency countdown and response data registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_misaligned <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
        end else begin
            if (w_accept) begin
                r_cnt        <= CNT_LOAD;
                r_write      <= req_write;
                r_idx        <= req_addr[AW+1:2];
                r_wdata      <= req_wdata;
                r_misaligned <= w_req_misaligned;
            end else if (r_state == BUSY && r_cnt != '0) begin
                r_cnt <= r_cnt - CW'(1);
            end

            if (w_done) begin
                r_err   <= r_misaligned;
                r_rdata <= (r_write || r_misaligned) ? 32'h0 : r_mem[r_idx];
            end else if (r_state == RESP && resp_ready) begin
                r_err   <= 1'b0;
                r_rdata <= 32'h0;
            end
        end
    end

    // Stores commit on the BUSY->RESP edge; contents survive reset.
    assign w_mem_we = w_done && r_write && !r_misaligned;

    // Memory array write port.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_idx] <= r_wdata;
        end
    end

    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - self-checking bench for data_memory_responder
module tb_data_memory_responder;
    localparam int DEPTH   = 16384;
    localparam int LATENCY = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;
    logic [31:0] model_mem [int];

    data_memory_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // One complete request/response exchange; the response is held for 'hold' cycles.
    task automatic transact(input bit w, input logic [31:0] a, input logic [31:0] d, input int hold,
                            output logic [31:0] rd, output logic er, output int lat,
                            output bit stable_ok, output bit after_ok);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; resp_ready = 1'b0;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; req_write = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 50) begin @(negedge clk); lat++; end
        rd = resp_rdata; er = resp_err; stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'($urandom_range(0, 1)); req_write = 1'($urandom);
            req_addr = $urandom; req_wdata = $urandom;
            @(negedge clk);
            if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er)
                stable_ok = 1'b0;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        after_ok = (resp_valid === 1'b0 && req_ready === 1'b1 && resp_rdata === 32'h0 && resp_err === 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        total++; if ({req_ready, resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            bad++; $display("FAIL reset_low: got rdy=%b vld=%b rd=%h err=%b want 1 0 0 0", req_ready, resp_valid, resp_rdata, resp_err); end
        reset = 1'b1;
        @(negedge clk);
        total++; if ({req_ready, resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            bad++; $display("FAIL reset_release: got rdy=%b vld=%b rd=%h err=%b want 1 0 0 0", req_ready, resp_valid, resp_rdata, resp_err); end
    endtask

    task automatic test_store_load();
        logic [31:0] rd; logic er; int lat; bit s_ok, a_ok;
        transact(1'b1, 32'h40, 32'hDEADBEEF, 0, rd, er, lat, s_ok, a_ok);
        model_mem[idx_of(32'h40)] = 32'hDEADBEEF;
        total++; if (lat !== LATENCY) begin bad++; $display("FAIL store_latency: got %0d want %0d", lat, LATENCY); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL store_rdata: got %h want 0", rd); end
        total++; if (a_ok !== 1'b1) begin bad++; $display("FAIL store_after_handshake: got %b want 1", a_ok); end
        transact(1'b0, 32'h40, 32'h0, 0, rd, er, lat, s_ok, a_ok);
        total++; if (lat !== LATENCY) begin bad++; $display("FAIL load_latency: got %0d want %0d", lat, LATENCY); end
        total++; if (rd !== 32'hDEADBEEF) begin bad++; $display("FAIL load_rdata: got %h want deadbeef", rd); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL load_err: got %b want 0", er); end
    endtask

    task automatic test_stall();
        logic [31:0] rd; logic er; int lat; bit s_ok, a_ok;
        transact(1'b0, 32'h40, 32'h0, 5, rd, er, lat, s_ok, a_ok);
        total++; if (rd !== model_mem[idx_of(32'h40)]) begin bad++; $display("FAIL stall_rdata: got %h want %h", rd, model_mem[idx_of(32'h40)]); end
        total++; if (s_ok !== 1'b1) begin bad++; $display("FAIL stall_held_stable: got %b want 1", s_ok); end
        total++; if (a_ok !== 1'b1) begin bad++; $display("FAIL stall_after_handshake: got %b want 1", a_ok); end
    endtask

    task automatic test_wrap();
        logic [31:0] rd; logic er; int lat; bit s_ok, a_ok;
        transact(1'b1, 32'h0, 32'h12345678, 1, rd, er, lat, s_ok, a_ok);
        model_mem[0] = 32'h12345678;
        transact(1'b0, 32'h10000, 32'h0, 0, rd, er, lat, s_ok, a_ok);
        total++; if (rd !== 32'h12345678) begin bad++; $display("FAIL wrap_rdata: got %h want 12345678", rd); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd; logic er; int lat; bit s_ok, a_ok;
        transact(1'b1, 32'h80, 32'h11111111, 0, rd, er, lat, s_ok, a_ok);
        model_mem[idx_of(32'h80)] = 32'h11111111;
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h80; req_wdata = 32'h22222222;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL mid_accepted: got rdy=%b want 0", req_ready); end
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if ({req_ready, resp_valid, resp_rdata, resp_err} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            bad++; $display("FAIL mid_reset_outputs: got rdy=%b vld=%b rd=%h err=%b want 1 0 0 0", req_ready, resp_valid, resp_rdata, resp_err); end
        @(negedge clk);
        total++; if ({req_ready, resp_valid} !== 2'b10) begin bad++; $display("FAIL mid_reset_held: got rdy=%b vld=%b want 1 0", req_ready, resp_valid); end
        reset = 1'b1;
        transact(1'b0, 32'h80, 32'h0, 0, rd, er, lat, s_ok, a_ok);
        total++; if (rd !== 32'h11111111) begin bad++; $display("FAIL mid_reset_dropped_store: got %h want 11111111", rd); end
    endtask

    task automatic test_align();
        logic [31:0] rd; logic er; int lat; bit s_ok, a_ok;
        logic exp_err;
`ifdef DMEM_ALIGN_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
        model_mem[idx_of(32'h42)] = 32'hAAAAAAAA;
`endif
        transact(1'b1, 32'h42, 32'hAAAAAAAA, 2, rd, er, lat, s_ok, a_ok);
        total++; if (er !== exp_err) begin bad++; $display("FAIL align_store_err: got %b want %b", er, exp_err); end
        total++; if (rd !== 32'h0) begin bad++; $display("FAIL align_store_rdata: got %h want 0", rd); end
        total++; if (lat !== LATENCY) begin bad++; $display("FAIL align_latency: got %0d want %0d", lat, LATENCY); end
        total++; if (a_ok !== 1'b1) begin bad++; $display("FAIL align_after_handshake: got %b want 1", a_ok); end
        transact(1'b0, 32'h40, 32'h0, 0, rd, er, lat, s_ok, a_ok);
        total++; if (rd !== model_mem[idx_of(32'h40)]) begin bad++; $display("FAIL align_load_rdata: got %h want %h", rd, model_mem[idx_of(32'h40)]); end
        total++; if (er !== 1'b0) begin bad++; $display("FAIL align_load_err: got %b want 0", er); end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat; bit s_ok, a_ok;
        int pool [6];
        int idx; bit w; logic [31:0] a, d, exp;
        for (int i = 0; i < 6; i++) pool[i] = int'($urandom_range(0, DEPTH - 1));
        for (int t = 0; t < 24; t++) begin
            idx = pool[$urandom_range(0, 5)];
            w = !model_mem.exists(idx) || ($urandom_range(0, 1) == 1);
            a = ($urandom << (2 + $clog2(DEPTH))) | (32'(idx) << 2);
            d = $urandom;
            exp = w ? 32'h0 : model_mem[idx];
            transact(w, a, d, int'($urandom_range(0, 3)), rd, er, lat, s_ok, a_ok);
            if (w) model_mem[idx] = d;
            total++; if (rd !== exp) begin bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", t, rd, exp); end
            total++; if (er !== 1'b0) begin bad++; $display("FAIL rand_err[%0d]: got %b want 0", t, er); end
            total++; if (lat !== LATENCY) begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", t, lat, LATENCY); end
            total++; if (s_ok !== 1'b1) begin bad++; $display("FAIL rand_stable[%0d]: got %b want 1", t, s_ok); end
            total++; if (a_ok !== 1'b1) begin bad++; $display("FAIL rand_after[%0d]: got %b want 1", t, a_ok); end
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_stall();
        test_wrap();
        test_reset_mid();
        test_align();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
